// File: rtl/mem_write_scheduler_if.sv
// Requester and memory-write bundle for mem_write_scheduler.
// The master side drives requests and observes grants and writes; the scheduler is the slave.
interface mem_write_scheduler_if #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][AW-1:0]        req_addr;
  logic [NUM_REQ-1:0][WIDTH-1:0]     req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              we;
  logic [AW-1:0]                     waddr;
  logic [WIDTH-1:0]                  wdata;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, we, waddr, wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, we, waddr, wdata
  );
endinterface

// File: rtl/mem_write_scheduler.sv
// Round-robin write scheduler for a single-port memory, with a zeroing sweep
// (INIT) after reset or clear before arbitration (RUN) begins.
module mem_write_scheduler #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  busy,
  mem_write_scheduler_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  logic [AW-1:0]       cnt;
  logic [PW-1:0]       ptr;
  logic                we_p1;
  logic [AW-1:0]       waddr_p1;
  logic [WIDTH-1:0]    wdata_p1;

  logic [NUM_REQ-1:0]  gnt_vec;
  logic [PW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [PW-1:0]       scan_idx;
  logic [PW-1:0]       ptr_next;

  // Stage p0: combinational round-robin search starting at ptr
  always_comb begin
    gnt_vec  = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    if (state == RUN && !clear) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = PW'((int'(ptr) + k) % NUM_REQ);
        if (!gnt_any && bus.req_valid[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
      if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
    end
  end

  assign ptr_next      = PW'((int'(gnt_idx) + 1) % NUM_REQ);
  assign bus.req_ready = gnt_vec;
  assign busy          = (state == INIT);

  // Stage p1: registered memory write port and control state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      cnt      <= '0;
      ptr      <= '0;
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      case (state)
        INIT: begin
          if (clear) begin
            cnt   <= '0;
            we_p1 <= 1'b0;
          end else begin
            we_p1    <= 1'b1;
            waddr_p1 <= cnt;
            wdata_p1 <= '0;
            // Wrap explicitly at DEPTH-1 so non-power-of-two depths stay in range.
            if (cnt == AW'(DEPTH - 1)) begin
              cnt   <= '0;
              state <= RUN;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        RUN: begin
          if (clear) begin
            we_p1 <= 1'b0;
            cnt   <= '0;
            state <= INIT;
          end else if (gnt_any) begin
            we_p1    <= 1'b1;
            waddr_p1 <= bus.req_addr[gnt_idx];
            wdata_p1 <= bus.req_data[gnt_idx];
            ptr      <= ptr_next;
          end else begin
            we_p1 <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.we    = we_p1;
  assign bus.waddr = waddr_p1;
  assign bus.wdata = wdata_p1;
endmodule

// File: tb/tb_mem_write_scheduler.sv
// Directed bench for mem_write_scheduler: reset sweep, table-driven arbitration,
// and hand-written clear / asynchronous-reset sequences.
module tb_mem_write_scheduler;
  localparam int WIDTH   = 64;
  localparam int DEPTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int AW      = $clog2(DEPTH);

  logic clock;
  logic reset;
  logic clear;
  logic busy;

  mem_write_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) bus ();

  mem_write_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] ready;
    logic               we;
    logic [AW-1:0]      waddr;
    logic [WIDTH-1:0]   wdata;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Checks n sweep writes starting at address 0; caller is just past an edge.
  task automatic sweep_check(input int n);
    for (int k = 0; k < n; k++) begin
      chk("sweep_ready", 64'(bus.req_ready), 64'h0);
      @(posedge clock); #1;
      chk("sweep_we",    64'(bus.we),    64'h1);
      chk("sweep_waddr", 64'(bus.waddr), 64'(k));
      chk("sweep_wdata", 64'(bus.wdata), 64'h0);
      chk("sweep_busy",  64'(busy),      (k == DEPTH - 1) ? 64'h0 : 64'h1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Fixed per-requester address/data; requester 2 carries addr 5, data 0xAB.
    bus.req_addr[0] = 5'd1;  bus.req_data[0] = 64'h11;
    bus.req_addr[1] = 5'd3;  bus.req_data[1] = 64'h22;
    bus.req_addr[2] = 5'd5;  bus.req_data[2] = 64'hAB;
    bus.req_addr[3] = 5'd7;  bus.req_data[3] = 64'h44;

    tbl[0]  = '{4'b1111, 4'b0001, 1'b1, 5'd1, 64'h11};
    tbl[1]  = '{4'b1111, 4'b0010, 1'b1, 5'd3, 64'h22};
    tbl[2]  = '{4'b1111, 4'b0100, 1'b1, 5'd5, 64'hAB};
    tbl[3]  = '{4'b1111, 4'b1000, 1'b1, 5'd7, 64'h44};
    tbl[4]  = '{4'b1111, 4'b0001, 1'b1, 5'd1, 64'h11};
    tbl[5]  = '{4'b1111, 4'b0010, 1'b1, 5'd3, 64'h22};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 5'd3, 64'h22};
    tbl[7]  = '{4'b0001, 4'b0001, 1'b1, 5'd1, 64'h11};
    tbl[8]  = '{4'b1001, 4'b1000, 1'b1, 5'd7, 64'h44};
    tbl[9]  = '{4'b1001, 4'b0001, 1'b1, 5'd1, 64'h11};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 5'd1, 64'h11};
    tbl[11] = '{4'b1000, 4'b1000, 1'b1, 5'd7, 64'h44};
    tbl[12] = '{4'b0100, 4'b0100, 1'b1, 5'd5, 64'hAB};
    tbl[13] = '{4'b1111, 4'b1000, 1'b1, 5'd7, 64'h44};
    tbl[14] = '{4'b0110, 4'b0010, 1'b1, 5'd3, 64'h22};
    tbl[15] = '{4'b0110, 4'b0100, 1'b1, 5'd5, 64'hAB};
    tbl[16] = '{4'b0011, 4'b0001, 1'b1, 5'd1, 64'h11};

    reset = 1'b0;
    clear = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_busy",  64'(busy),          64'h1);
    chk("rst_we",    64'(bus.we),        64'h0);
    chk("rst_waddr", 64'(bus.waddr),     64'h0);
    chk("rst_wdata", 64'(bus.wdata),     64'h0);
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_we", 64'(bus.we), 64'h0);
    #1 reset = 1'b1;

    // Sweep after reset release, requests pending throughout
    sweep_check(DEPTH);

    // Arbitration vectors, ptr starts at 0
    for (int i = 0; i < NVEC; i++) begin
      bus.req_valid = tbl[i].valid;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].ready));
      @(posedge clock); #1;
      chk($sformatf("v%0d_we", i),    64'(bus.we),    64'(tbl[i].we));
      chk($sformatf("v%0d_waddr", i), 64'(bus.waddr), 64'(tbl[i].waddr));
      chk($sformatf("v%0d_wdata", i), 64'(bus.wdata), 64'(tbl[i].wdata));
      chk($sformatf("v%0d_busy", i),  64'(busy),      64'h0);
    end

    // Clear in RUN with all requesters valid; ptr is 1 here
    bus.req_valid = 4'b1111;
    clear = 1'b1;
    #1;
    chk("clr_run_ready", 64'(bus.req_ready), 64'h0);
    @(posedge clock); #1;
    chk("clr_run_we",   64'(bus.we), 64'h0);
    chk("clr_run_busy", 64'(busy),   64'h1);
    clear = 1'b0;
    sweep_check(DEPTH);
    chk("resume_ready", 64'(bus.req_ready), 64'b0010);
    @(posedge clock); #1;
    chk("resume_we",    64'(bus.we),    64'h1);
    chk("resume_waddr", 64'(bus.waddr), 64'd3);
    chk("resume_wdata", 64'(bus.wdata), 64'h22);

    // Asynchronous reset at sweep cnt=10
    bus.req_valid = 4'b0000;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("pre_rst_we", 64'(bus.we), 64'h0);
    sweep_check(10);
    bus.req_valid = 4'b1111;
    #1 reset = 1'b0;
    #1;
    chk("async_rst_we",    64'(bus.we),        64'h0);
    chk("async_rst_waddr", 64'(bus.waddr),     64'h0);
    chk("async_rst_wdata", 64'(bus.wdata),     64'h0);
    chk("async_rst_busy",  64'(busy),          64'h1);
    chk("async_rst_ready", 64'(bus.req_ready), 64'h0);
    @(posedge clock); #1;
    chk("async_rst_hold_we", 64'(bus.we), 64'h0);
    #1 reset = 1'b1;
    sweep_check(DEPTH);

    // Clear held for several cycles, then a clear pulse at sweep cnt=20
    bus.req_valid = 4'b0000;
    clear = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk("clr_hold_we",   64'(bus.we), 64'h0);
      chk("clr_hold_busy", 64'(busy),   64'h1);
    end
    clear = 1'b0;
    sweep_check(20);
    clear = 1'b1;
    @(posedge clock); #1;
    chk("clr_init_we",   64'(bus.we), 64'h0);
    chk("clr_init_busy", 64'(busy),   64'h1);
    clear = 1'b0;
    sweep_check(DEPTH);
    chk("final_busy", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
